mem_dtlb_buffer: RTL and testbench
==================================

// Module: mem_dtlb_buffer
// PURPOSE
//  Multi-entry, fully associative data micro-TLB for the MEM stage; successor of the single-entry D-side TLB buffer.
//  Translates MEM_ALUOut to a physical address and cacheability, and flags D-side TLB exceptions.
//  On a mapped miss it stalls the pipe and refills from the main TLB's second search port (s1).
//  Sits between the MEM pipe register and the Dcache request (tag, isCache, valid qualification).
// PARAMETERS
//  ENTRIES   4   buffer entries, >=2, power of two; round-robin victim pointer is $clog2(ENTRIES) bits
//  ASID_W    8   ASID width
//  PFN_W     20  PFN width; paddr = {pfn, vaddr[11:0]}
// PORTS
//  clk            in   1      clock
//  rst            in   1      synchronous active-high reset
//  flush          in   1      invalidate all entries (TLBR/TLBW/MTC0 EntryHi retire, already DisWr-gated)
//  req_valid      in   1      MEM-stage memory access present (load or store)
//  req_vaddr      in   32     virtual data address
//  req_is_store   in   1      1 = store, 0 = load
//  cp0_asid       in   ASID_W EntryHi.ASID
//  cp0_config_k0  in   3      Config.K0; 3'b011 = cached
//  refill_req     out  1      request main-TLB lookup of refill_vpn2
//  refill_vpn2    out  19     VPN2 (vaddr[31:13]) being refilled
//  refill_valid   in   1      one-cycle pulse: main TLB answer valid
//  refill_found   in   1      main TLB hit (s1_found)
//  refill_entry   in   TLB_Entry  matched entry: VPN2, ASID, G, PFN0/C0/D0/V0, PFN1/C1/D1/V1
//  paddr          out  32     physical address
//  is_cached      out  1      cacheable access
//  hit            out  1      translation valid this cycle (Dcache valid qualifier)
//  stall          out  1      hold MEM and earlier stages
//  exc_type       out  3      0 none, 1 TLBL refill, 2 TLBL invalid, 3 TLBS refill, 4 TLBS invalid, 5 TLB Mod
// BEHAVIOUR
//  Reset: all entries invalid, victim ptr 0, miss marker clear, FSM IDLE.
//   With req_valid=0, every output is 0 (refill_vpn2 = 0).
//  Segments: vaddr[31:29]=100 (kseg0) -> paddr = {3'b000, vaddr[28:0]}, is_cached = (K0==3), hit=1, no TLB.
//   101 (kseg1) -> same paddr, is_cached=0, hit=1. Anything else is mapped.
//  Lookup (combinational, 0 latency): match = entry valid & VPN2 == vaddr[31:13] & (G | ASID == cp0_asid).
//   Half select by vaddr[12]. At most one match; refill never duplicates.
//  Mapped hit: paddr = {PFN, vaddr[11:0]}, is_cached = (C == 3).
//   V=0 -> exc 2 or 4, hit=0. Store with D=0 -> exc 5, hit=0. Otherwise hit=1, exc 0.
//  Mapped miss with the miss marker set for {vaddr[31:13], asid}: exc 1 (load) or 3 (store), hit=0, stall=0.
//  Mapped miss otherwise: stall=1, hit=0, exc 0.
//  FSM IDLE -> WAIT when req_valid & mapped miss & !flush & no marker.
//   WAIT: refill_req=1, refill_vpn2 = vaddr[31:13], stall=1.
//   WAIT & refill_valid & found: write refill_entry into the victim, go IDLE; hit next cycle. Victim = lowest-index invalid entry, else ptr, then ptr++ mod ENTRIES.
//   WAIT & refill_valid & !found: set miss marker {vpn2, asid}, go IDLE; exc 1/3 next cycle, no stall.
//   WAIT holds with no timeout until refill_valid.
//  flush: next cycle all entries invalid and marker clear. In WAIT -> IDLE and any same-cycle refill_valid is discarded.
//   Flush has priority over refill write.
//  Marker cleared by flush, by any refill write, or when IDLE sees req_valid with a different {vpn2, asid}.
//  refill_valid in IDLE is ignored.
//  rst mid-WAIT: return to reset state; a later refill_valid is ignored.
//  Stall is asserted only by this block's own FSM; requests stay stable while stall=1.
// TESTING
//  T1 reset; load 0x8000_1234, K0=3 -> paddr 0x0000_1234, cached, hit=1, no refill_req.
//  T2 load 0x0040_2008, empty buffer -> stall 1 cycle; refill_req vpn2=0x00201.
//   Refill found, PFN0=0x12345, V0=1, C0=3 -> next cycle paddr 0x1234_5008, hit=1, stall=0.
//  T3 store 0x0040_3000, refill returns D1=0 -> exc 5, hit=0. Load to same addr -> exc 0, hit=1.
//  T4 refill_found=0 for load 0x7000_0000 -> one stall cycle, then exc 1, stall=0.
//   Change ASID -> marker cleared, new refill_req.
//  T5 fill ENTRIES+1 distinct VPN2s -> entry 0 evicted (ptr wraps); its VPN2 misses again, the other ENTRIES hit.
//  T6 flush in the same cycle as refill_valid&found -> no entry written, FSM IDLE, all lookups miss next cycle.

Source files
------------

// File: rtl/mem_dtlb_buffer.sv
// Fully associative data micro-TLB for the MEM stage: kseg0/kseg1 bypass, mapped lookup, refill from main TLB.
// Latency: lookup and outputs are combinational (0 cycles); a refill write is visible the cycle after refill_valid.
// Backpressure: stall is raised on a mapped miss and held while waiting for the main TLB answer, with no timeout.
module mem_dtlb_buffer #(
    parameter int ENTRIES = 4,
    parameter int ASID_W  = 8,
    parameter int PFN_W   = 20,
    localparam int HALF_W  = PFN_W + 5,
    localparam int ENTRY_W = 19 + ASID_W + 1 + 2 * HALF_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               req_valid,
    input  logic [31:0]        req_vaddr,
    input  logic               req_is_store,
    input  logic [ASID_W-1:0]  cp0_asid,
    input  logic [2:0]         cp0_config_k0,
    output logic               refill_req,
    output logic [18:0]        refill_vpn2,
    input  logic               refill_valid,
    input  logic               refill_found,
    input  logic [ENTRY_W-1:0] refill_entry,
    output logic [31:0]        paddr,
    output logic               is_cached,
    output logic               hit,
    output logic               stall,
    output logic [2:0]         exc_type
);

    // Entry layout, MSB to LSB: VPN2, ASID, G, {PFN0,C0,D0,V0}, {PFN1,C1,D1,V1}.
    // Each half is {PFN, C[2:0], D, V}.
    localparam int IDX_W    = $clog2(ENTRIES);
    localparam int G_BIT    = 2 * HALF_W;
    localparam int ASID_LSB = G_BIT + 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ENTRIES-1:0]  e_vld;
    logic [ENTRY_W-1:0]  e_dat [ENTRIES];
    logic [IDX_W-1:0]    ptr;
    logic [IDX_W-1:0]    victim;
    logic                marker_vld;
    logic [18:0]         marker_vpn2;
    logic [ASID_W-1:0]   marker_asid;

    logic                match_any;
    logic [HALF_W-1:0]   sel_half;
    logic                unmapped;
    logic                marker_hit;
    logic                refill_wr;
    logic                miss_wr;

    // Associative match across all entries; the refill path never creates duplicates.
    always_comb begin
        match_any = 1'b0;
        sel_half  = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (e_vld[i]
                && e_dat[i][ENTRY_W-1 -: 19] == req_vaddr[31:13]
                && (e_dat[i][G_BIT] || e_dat[i][ASID_LSB +: ASID_W] == cp0_asid)) begin
                match_any = 1'b1;
                sel_half  = req_vaddr[12] ? e_dat[i][HALF_W-1:0] : e_dat[i][2*HALF_W-1:HALF_W];
            end
        end
    end

    // Victim: lowest-index free slot, otherwise the round-robin pointer.
    always_comb begin
        victim = ptr;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!e_vld[i]) begin
                victim = IDX_W'(i);
            end
        end
    end

    assign unmapped   = (req_vaddr[31:29] == 3'b100) || (req_vaddr[31:29] == 3'b101);
    assign marker_hit = marker_vld && marker_vpn2 == req_vaddr[31:13] && marker_asid == cp0_asid;
    assign refill_wr  = (state == S_WAIT) && refill_valid && refill_found && !flush;
    assign miss_wr    = (state == S_WAIT) && refill_valid && !refill_found && !flush;

    // Translation outputs and FSM next state; everything is quiet without a request.
    always_comb begin
        paddr       = '0;
        is_cached   = 1'b0;
        hit         = 1'b0;
        stall       = 1'b0;
        exc_type    = 3'd0;
        refill_req  = 1'b0;
        refill_vpn2 = '0;
        state_nxt   = state;

        if (req_valid) begin
            if (unmapped) begin
                paddr     = {3'b000, req_vaddr[28:0]};
                is_cached = (req_vaddr[31:29] == 3'b100) && (cp0_config_k0 == 3'b011);
                hit       = 1'b1;
            end else if (state == S_WAIT) begin
                stall       = 1'b1;
                refill_req  = 1'b1;
                refill_vpn2 = req_vaddr[31:13];
            end else if (match_any) begin
                paddr     = {sel_half[HALF_W-1:5], req_vaddr[11:0]};
                is_cached = (sel_half[4:2] == 3'b011);
                if (!sel_half[0]) begin
                    exc_type = req_is_store ? 3'd4 : 3'd2;
                end else if (req_is_store && !sel_half[1]) begin
                    exc_type = 3'd5;
                end else begin
                    hit = 1'b1;
                end
            end else if (marker_hit) begin
                exc_type = req_is_store ? 3'd3 : 3'd1;
            end else begin
                stall = 1'b1;
            end
        end

        case (state)
            S_IDLE: begin
                if (req_valid && !unmapped && !match_any && !marker_hit && !flush) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush || refill_valid) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Control state: FSM, valid bits, victim pointer and the refill-miss marker; flush wins over refill.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            e_vld       <= '0;
            ptr         <= '0;
            marker_vld  <= 1'b0;
            marker_vpn2 <= '0;
            marker_asid <= '0;
        end else begin
            state <= state_nxt;
            if (flush) begin
                e_vld      <= '0;
                marker_vld <= 1'b0;
            end else if (refill_wr) begin
                e_vld[victim] <= 1'b1;
                ptr           <= ptr + IDX_W'(1);
                marker_vld    <= 1'b0;
            end else if (miss_wr) begin
                marker_vld  <= 1'b1;
                marker_vpn2 <= req_vaddr[31:13];
                marker_asid <= cp0_asid;
            end else if (state == S_IDLE && req_valid && marker_vld && !marker_hit) begin
                marker_vld <= 1'b0;
            end
        end
    end

    // Entry payload; only meaningful where the matching valid bit is set.
    always_ff @(posedge clk) begin
        if (refill_wr) begin
            e_dat[victim] <= refill_entry;
        end
    end

endmodule

// File: tb/tb_mem_dtlb_buffer.sv
// Directed bench for mem_dtlb_buffer: expected outputs are queued per step and checked mid-cycle.
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Refill responses and flush are one-cycle pulses cleared automatically after each step.
module tb_mem_dtlb_buffer;

    localparam int ENTRIES = 4;
    localparam int ENTRY_W = 78;

    typedef struct packed {
        logic [31:0] paddr;
        logic        cached;
        logic        hit;
        logic        stall;
        logic [2:0]  exc;
        logic        rreq;
        logic [18:0] vpn2;
        logic        dc;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               flush;
    logic               req_valid;
    logic [31:0]        req_vaddr;
    logic               req_is_store;
    logic [7:0]         cp0_asid;
    logic [2:0]         cp0_config_k0;
    logic               refill_req;
    logic [18:0]        refill_vpn2;
    logic               refill_valid;
    logic               refill_found;
    logic [ENTRY_W-1:0] refill_entry;
    logic [31:0]        paddr;
    logic               is_cached;
    logic               hit;
    logic               stall;
    logic [2:0]         exc_type;

    exp_t  sb[$];
    string tag_q[$];
    int    n_vec = 0;
    int    n_err = 0;

    mem_dtlb_buffer #(.ENTRIES(ENTRIES), .ASID_W(8), .PFN_W(20)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_vaddr(req_vaddr), .req_is_store(req_is_store),
        .cp0_asid(cp0_asid), .cp0_config_k0(cp0_config_k0),
        .refill_req(refill_req), .refill_vpn2(refill_vpn2),
        .refill_valid(refill_valid), .refill_found(refill_found), .refill_entry(refill_entry),
        .paddr(paddr), .is_cached(is_cached), .hit(hit), .stall(stall), .exc_type(exc_type)
    );

    always #5 clk = ~clk;

    function automatic logic [ENTRY_W-1:0] mk(
        input logic [18:0] vpn2, input logic [7:0] asid, input logic g,
        input logic [19:0] pfn0, input logic [2:0] c0, input logic d0, input logic v0,
        input logic [19:0] pfn1, input logic [2:0] c1, input logic d1, input logic v1);
        return {vpn2, asid, g, pfn0, c0, d0, v0, pfn1, c1, d1, v1};
    endfunction

    task automatic check();
        exp_t  e;
        string t;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard_empty: got no expectation, want one queued");
            return;
        end
        e = sb.pop_front();
        t = tag_q.pop_front();
        n_vec++;
        assert (hit === e.hit) else begin
            n_err++; $error("FAIL %s hit: got %b want %b", t, hit, e.hit);
        end
        assert (stall === e.stall) else begin
            n_err++; $error("FAIL %s stall: got %b want %b", t, stall, e.stall);
        end
        assert (exc_type === e.exc) else begin
            n_err++; $error("FAIL %s exc_type: got %0d want %0d", t, exc_type, e.exc);
        end
        assert (refill_req === e.rreq) else begin
            n_err++; $error("FAIL %s refill_req: got %b want %b", t, refill_req, e.rreq);
        end
        assert (refill_vpn2 === e.vpn2) else begin
            n_err++; $error("FAIL %s refill_vpn2: got %h want %h", t, refill_vpn2, e.vpn2);
        end
        if (!e.dc) begin
            assert (paddr === e.paddr) else begin
                n_err++; $error("FAIL %s paddr: got %h want %h", t, paddr, e.paddr);
            end
            assert (is_cached === e.cached) else begin
                n_err++; $error("FAIL %s is_cached: got %b want %b", t, is_cached, e.cached);
            end
        end
    endtask

    // One clock of stimulus: queue the expectation, check mid-cycle, then release pulses.
    task automatic step(input string tag, input logic [31:0] ep, input logic ec, input logic eh,
                        input logic es, input logic [2:0] ee, input logic er,
                        input logic [18:0] ev, input logic dc);
        sb.push_back('{paddr: ep, cached: ec, hit: eh, stall: es, exc: ee, rreq: er, vpn2: ev, dc: dc});
        tag_q.push_back(tag);
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
        refill_valid = 1'b0;
        refill_found = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic req(input logic [31:0] va, input logic st);
        req_valid    = 1'b1;
        req_vaddr    = va;
        req_is_store = st;
    endtask

    task automatic exp_zero(input string tag);
        step(tag, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 19'h0, 1'b0);
    endtask

    task automatic exp_hit(input string tag, input logic [31:0] pa, input logic c);
        step(tag, pa, c, 1'b1, 1'b0, 3'd0, 1'b0, 19'h0, 1'b0);
    endtask

    task automatic exp_stall(input string tag);
        step(tag, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 19'h0, 1'b1);
    endtask

    task automatic exp_wait(input string tag, input logic [18:0] vpn);
        step(tag, 32'h0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b1, vpn, 1'b1);
    endtask

    // Mapped miss: one IDLE stall cycle, then the WAIT cycle in which the main TLB answers.
    task automatic fill(input string tag, input logic [31:0] va, input logic st,
                        input logic [ENTRY_W-1:0] ent, input logic found);
        req(va, st);
        exp_stall({tag, "_miss"});
        refill_valid = 1'b1;
        refill_found = found;
        refill_entry = ent;
        exp_wait({tag, "_wait"}, va[31:13]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] va;
        logic [18:0] vp;
        rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_vaddr = '0; req_is_store = 1'b0;
        cp0_asid = 8'h01; cp0_config_k0 = 3'b011;
        refill_valid = 1'b0; refill_found = 1'b0; refill_entry = '0;
        @(posedge clk);
        #1;

        // T1: reset and unmapped segments
        exp_zero("rst_out");
        rst = 1'b0;
        exp_zero("idle_out");
        req(32'h8000_1234, 1'b0);
        exp_hit("kseg0_cached", 32'h0000_1234, 1'b1);
        cp0_config_k0 = 3'b010;
        exp_hit("kseg0_uncached", 32'h0000_1234, 1'b0);
        cp0_config_k0 = 3'b011;
        req(32'hA000_0010, 1'b0);
        exp_hit("kseg1", 32'h0000_0010, 1'b0);

        // T2: refill on empty buffer
        fill("t2", 32'h0040_2008, 1'b0,
             mk(19'h00201, 8'h01, 1'b0, 20'h12345, 3'd3, 1'b1, 1'b1, 20'h54321, 3'd2, 1'b0, 1'b1), 1'b1);
        exp_hit("t2_hit", 32'h1234_5008, 1'b1);
        req(32'h0040_2008, 1'b1);
        exp_hit("t2_store_hit", 32'h1234_5008, 1'b1);

        // T3: odd half, D=0 -> modify exception on store only
        req(32'h0040_3000, 1'b1);
        step("t3_mod", 32'h5432_1000, 1'b0, 1'b0, 1'b0, 3'd5, 1'b0, 19'h0, 1'b0);
        req(32'h0040_3000, 1'b0);
        exp_hit("t3_load", 32'h5432_1000, 1'b0);

        // T4: main-TLB miss sets the marker; ASID change clears it
        fill("t4", 32'h7000_0000, 1'b0, '0, 1'b0);
        step("t4_exc_load", 32'h0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 19'h0, 1'b1);
        step("t4_exc_again", 32'h0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0, 19'h0, 1'b1);
        req(32'h7000_0000, 1'b1);
        step("t4_exc_store", 32'h0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0, 19'h0, 1'b1);
        cp0_asid = 8'h02;
        fill("t4_asid", 32'h7000_0000, 1'b0,
             mk(19'h38000, 8'h02, 1'b0, 20'h00777, 3'd3, 1'b0, 1'b0, 20'h0, 3'd0, 1'b0, 1'b0), 1'b1);
        step("t4_inv_load", 32'h0077_7000, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 19'h0, 1'b0);
        req(32'h7000_0000, 1'b1);
        step("t4_inv_store", 32'h0077_7000, 1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 19'h0, 1'b0);

        // T5: ENTRIES+1 global fills from reset; entry 0 is the one evicted
        rst = 1'b1;
        req_valid = 1'b0;
        exp_zero("t5_rst");
        rst = 1'b0;
        for (int i = 0; i <= ENTRIES; i++) begin
            vp = 19'h00100 + 19'(i);
            va = {vp, 13'h0ABC};
            fill("t5_fill", va, 1'b0,
                 mk(vp, 8'h00, 1'b1, 20'h00A00 + 20'(i), 3'd3, 1'b1, 1'b1,
                    20'h00B00 + 20'(i), 3'd3, 1'b1, 1'b1), 1'b1);
            exp_hit("t5_new_hit", {20'h00A00 + 20'(i), 12'hABC}, 1'b1);
        end
        for (int i = 1; i <= ENTRIES; i++) begin
            vp = 19'h00100 + 19'(i);
            req({vp, 13'h0ABC}, 1'b0);
            exp_hit("t5_kept", {20'h00A00 + 20'(i), 12'hABC}, 1'b1);
        end
        req({19'h00100, 13'h0ABC}, 1'b0);
        exp_stall("t5_evicted");

        // T6: flush together with a found refill -> nothing written, back to IDLE
        flush = 1'b1;
        refill_valid = 1'b1;
        refill_found = 1'b1;
        refill_entry = mk(19'h00100, 8'h00, 1'b1, 20'h00A00, 3'd3, 1'b1, 1'b1, 20'h00B00, 3'd3, 1'b1, 1'b1);
        exp_wait("t6_flush_wait", 19'h00100);
        req({19'h00101, 13'h0ABC}, 1'b0);
        exp_stall("t6_idle_miss");
        refill_valid = 1'b1;
        refill_found = 1'b0;
        exp_wait("t6_wait_again", 19'h00101);
        req({19'h00100, 13'h0ABC}, 1'b0);
        exp_stall("t6_not_written");
        req_valid = 1'b0;
        exp_zero("t6_no_req");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
